game_flow_ctrl: RTL and testbench
=================================

GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 Parameter LIVES_INIT, default 3: lives loaded at game start, range 1..3.
REQ-002 Parameter SERVE_FRAMES, default 60: frames held in SERVE and in LOST, range 1..255.
REQ-003 Parameter SPEEDUP_HITS, default 5: bar hits per ball-speed increment, range 1..15.
REQ-004 Parameter SPEED_INIT, default 3, and SPEED_MAX, default 8: ball speed start value and ceiling, SPEED_INIT <= SPEED_MAX <= 11.
REQ-005 Parameter BAR_SPEED_INIT, default 4: bar speed paired with SPEED_INIT.
REQ-006 I_clk  in  1  system clock, 100 MHz; the only clock.
REQ-007 I_rst  in  1  reset, synchronous, active-high.
REQ-008 I_vs  in  1  VGA vertical sync, active-low pulse once per frame.
REQ-009 I_start  in  1  start/serve button level.
REQ-010 I_hit  in  1  ball-on-bar contact level from the display block.
REQ-011 I_lose  in  1  miss level from the display block.
REQ-012 O_run  out  1  ball/bar motion enable.
REQ-013 O_ball_reset  out  1  hold the ball at the centre spawn position.
REQ-014 O_ball_speed  out  4  ball pixels per frame.
REQ-015 O_bar_speed  out  4  bar pixels per frame.
REQ-016 O_score  out  16  four BCD digits, [15:12] most significant.
REQ-017 O_lives  out  2  remaining lives.
REQ-018 O_state  out  3  encoded FSM state.
REQ-019 O_game_over  out  1  high while in OVER.

Function
REQ-020 I_vs, I_start, I_hit and I_lose each pass through a two-flop synchroniser followed by a previous-value flop for edge detection.
REQ-021 The frame tick is a one-cycle pulse on the synchronised falling edge of I_vs. Start, hit and lose events are one-cycle pulses on the synchronised rising edges of their inputs.
REQ-022 All outputs are registered. An input level change first sampled at clock edge k is reflected on the outputs at edge k+3.
REQ-023 The FSM has these states and encodings: IDLE=0, SERVE=1, PLAY=2, LOST=3, OVER=4; encodings 5-7 go to IDLE on the next edge.
REQ-024 IDLE and OVER: O_run=0, O_ball_reset=1.
- A start event loads lives=LIVES_INIT, score=0, ball speed=SPEED_INIT and hit count=0, clears the frame counter, and moves to SERVE.
REQ-025 SERVE: O_run=0, O_ball_reset=1.
- The frame counter increments on each tick.
- On the tick that makes the count equal SERVE_FRAMES, the counter clears and the FSM moves to PLAY.
REQ-026 PLAY: O_run=1, O_ball_reset=0.
- A hit event increments the score in BCD with decimal carry; 9999 saturates and does not wrap.
- A hit event increments the hit count.
- When the hit count would reach SPEEDUP_HITS, it clears instead and ball speed increments, saturating at SPEED_MAX.
REQ-027 PLAY: a lose event decrements lives, clears the frame counter and moves to LOST.
- If a lose event and a hit event coincide in the same cycle, lose wins and the hit is discarded.
REQ-028 LOST: O_run=0, O_ball_reset=1.
- After SERVE_FRAMES ticks, lives==0 moves to OVER.
- Otherwise the FSM moves to SERVE with ball speed=SPEED_INIT and hit count=0; score is kept.
REQ-029 O_bar_speed always equals BAR_SPEED_INIT + (O_ball_speed - SPEED_INIT), saturating at 15.
REQ-030 Start events in SERVE, PLAY and LOST are ignored, except as defined under REQ-037.
- Hit and lose events outside PLAY are ignored.
REQ-031 A frame tick coinciding with a state entry is not counted toward that state.

Reset
REQ-032 While I_rst is high at a rising edge, the following hold on the next edge: state=IDLE, O_run=0, O_ball_reset=1, O_ball_speed=SPEED_INIT, O_bar_speed=BAR_SPEED_INIT, O_score=0, O_lives=LIVES_INIT, O_game_over=0, and all counters and synchroniser flops are 0.
REQ-033 Reset asserted in any state, including mid-LOST or mid-SERVE count, aborts the game; no partial state survives.
REQ-034 Because synchroniser flops clear to 0, an input already held high when reset releases produces a rising-edge event.

Configuration
REQ-035 The feature macro is GAME_FLOW_PAUSE_EN.
REQ-036 Without GAME_FLOW_PAUSE_EN, state encoding 5 is unused and start events in PLAY are ignored.
REQ-037 With GAME_FLOW_PAUSE_EN, the PAUSE state uses encoding 5.
- A start event in PLAY moves to PAUSE: O_run=0, O_ball_reset=0, score, lives and speed frozen, hit and lose events ignored.
- The next start event returns to PLAY.

Verification
REQ-038 Reset with I_start high: start the bench with SERVE_FRAMES=4 and hold I_start high through reset release -> IDLE, then SERVE 3 edges after release; PLAY after 4 frame ticks.
REQ-039 Score carry: start from score 0x0099 in PLAY and apply one hit pulse -> O_score=0x0100. Start from 0x9999 and apply a hit -> O_score stays 0x9999.
REQ-040 Speed ramp: with SPEEDUP_HITS=5 and SPEED_INIT=3, apply 10 hit pulses -> O_ball_speed=5, O_bar_speed=6. Apply 40 more -> O_ball_speed=8 (saturated).
REQ-041 Hit and lose together: raise I_hit and I_lose on the same edge with lives=1 -> score unchanged, lives=0, LOST, then OVER after 4 ticks with O_game_over=1.
REQ-042 Mid-LOST reset: pulse I_rst during tick 2 of LOST -> all outputs at the REQ-032 values on the next edge.
REQ-043 GAME_FLOW_PAUSE_EN defined: start in PLAY -> O_state=5 and O_run=0; a hit while paused leaves the score unchanged; a second start -> O_state=2.

Source files
------------

// File: rtl/game_flow_ctrl_if.sv
// Bundle of the game-flow controller's control inputs and status outputs.
// The master side drives the input events; the slave side is the controller.
interface game_flow_ctrl_if;
  logic        I_vs;
  logic        I_start;
  logic        I_hit;
  logic        I_lose;
  logic        O_run;
  logic        O_ball_reset;
  logic [3:0]  O_ball_speed;
  logic [3:0]  O_bar_speed;
  logic [15:0] O_score;
  logic [1:0]  O_lives;
  logic [2:0]  O_state;
  logic        O_game_over;

  modport master (
    output I_vs, I_start, I_hit, I_lose,
    input  O_run, O_ball_reset, O_ball_speed, O_bar_speed,
    input  O_score, O_lives, O_state, O_game_over
  );

  modport slave (
    input  I_vs, I_start, I_hit, I_lose,
    output O_run, O_ball_reset, O_ball_speed, O_bar_speed,
    output O_score, O_lives, O_state, O_game_over
  );
endinterface

// File: rtl/game_flow_ctrl.sv
// Ball game flow FSM: serve/play/lost/over, BCD score, lives and speed ramp.
// Optional PAUSE state (encoding 5) enabled by defining GAME_FLOW_PAUSE_EN.
module game_flow_ctrl #(
  parameter int LIVES_INIT     = 3,
  parameter int SERVE_FRAMES   = 60,
  parameter int SPEEDUP_HITS   = 5,
  parameter int SPEED_INIT     = 3,
  parameter int SPEED_MAX      = 8,
  parameter int BAR_SPEED_INIT = 4
) (
  input logic I_clk,
  input logic I_rst,
  game_flow_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_LOST  = 3'd3,
`ifdef GAME_FLOW_PAUSE_EN
    S_OVER  = 3'd4,
    S_PAUSE = 3'd5
`else
    S_OVER  = 3'd4
`endif
  } state_t;

  localparam logic [7:0] FR_LAST  = 8'(SERVE_FRAMES - 1);
  localparam logic [3:0] HIT_LAST = 4'(SPEEDUP_HITS - 1);
  localparam logic [3:0] SP_INIT  = 4'(SPEED_INIT);
  localparam logic [3:0] SP_MAX   = 4'(SPEED_MAX);
  localparam logic [3:0] BAR_INIT = 4'(BAR_SPEED_INIT);
  localparam logic [1:0] LV_INIT  = 2'(LIVES_INIT);

  // bit order: 0=vs 1=start 2=hit 3=lose
  logic [3:0]  r_sync1, r_sync2, r_prev;
  logic        r_tick, r_start, r_hit, r_lose;

  state_t      r_state, w_state;
  logic [1:0]  r_lives, w_lives;
  logic [15:0] r_score, w_score;
  logic [3:0]  r_speed, w_speed;
  logic [3:0]  r_hcnt, w_hcnt;
  logic [7:0]  r_fcnt, w_fcnt;
  logic [3:0]  r_bar;
  logic        r_run, r_brst, r_over;
  logic        w_run, w_brst;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (c) begin
          if (r[i*4 +: 4] == 4'd9) begin
            r[i*4 +: 4] = 4'd0;
          end else begin
            r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  function automatic logic [3:0] bar_of(input logic [3:0] s);
    logic [4:0] t;
    t = 5'(BAR_SPEED_INIT) + 5'(s) - 5'(SPEED_INIT);
    return (t > 5'd15) ? 4'd15 : t[3:0];
  endfunction

  always_comb begin
    w_state = r_state;
    w_lives = r_lives;
    w_score = r_score;
    w_speed = r_speed;
    w_hcnt  = r_hcnt;
    w_fcnt  = r_fcnt;
    unique case (r_state)
      S_IDLE, S_OVER: begin
        if (r_start) begin
          w_lives = LV_INIT;
          w_score = 16'h0000;
          w_speed = SP_INIT;
          w_hcnt  = 4'd0;
          w_fcnt  = 8'd0;
          w_state = S_SERVE;
        end
      end
      S_SERVE: begin
        if (r_tick) begin
          if (r_fcnt == FR_LAST) begin
            w_fcnt  = 8'd0;
            w_state = S_PLAY;
          end else begin
            w_fcnt = r_fcnt + 8'd1;
          end
        end
      end
      S_PLAY: begin
        if (r_lose) begin
          w_lives = r_lives - 2'd1;
          w_fcnt  = 8'd0;
          w_state = S_LOST;
`ifdef GAME_FLOW_PAUSE_EN
        end else if (r_start) begin
          w_state = S_PAUSE;
`endif
        end else if (r_hit) begin
          w_score = bcd_inc(r_score);
          if (r_hcnt == HIT_LAST) begin
            w_hcnt = 4'd0;
            if (r_speed != SP_MAX) w_speed = r_speed + 4'd1;
          end else begin
            w_hcnt = r_hcnt + 4'd1;
          end
        end
      end
      S_LOST: begin
        if (r_tick) begin
          if (r_fcnt == FR_LAST) begin
            w_fcnt  = 8'd0;
            w_speed = SP_INIT;
            w_hcnt  = 4'd0;
            w_state = (r_lives == 2'd0) ? S_OVER : S_SERVE;
          end else begin
            w_fcnt = r_fcnt + 8'd1;
          end
        end
      end
`ifdef GAME_FLOW_PAUSE_EN
      S_PAUSE: begin
        if (r_start) w_state = S_PLAY;
      end
`endif
      default: w_state = S_IDLE;
    endcase
    w_run  = (w_state == S_PLAY);
`ifdef GAME_FLOW_PAUSE_EN
    w_brst = (w_state != S_PLAY) && (w_state != S_PAUSE);
`else
    w_brst = (w_state != S_PLAY);
`endif
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_sync1 <= 4'd0;
      r_sync2 <= 4'd0;
      r_prev  <= 4'd0;
      r_tick  <= 1'b0;
      r_start <= 1'b0;
      r_hit   <= 1'b0;
      r_lose  <= 1'b0;
      r_state <= S_IDLE;
      r_lives <= LV_INIT;
      r_score <= 16'h0000;
      r_speed <= SP_INIT;
      r_hcnt  <= 4'd0;
      r_fcnt  <= 8'd0;
      r_bar   <= BAR_INIT;
      r_run   <= 1'b0;
      r_brst  <= 1'b1;
      r_over  <= 1'b0;
    end else begin
      r_sync1 <= {bus.I_lose, bus.I_hit, bus.I_start, bus.I_vs};
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_tick  <= r_prev[0] & ~r_sync2[0];
      r_start <= r_sync2[1] & ~r_prev[1];
      r_hit   <= r_sync2[2] & ~r_prev[2];
      r_lose  <= r_sync2[3] & ~r_prev[3];
      r_state <= w_state;
      r_lives <= w_lives;
      r_score <= w_score;
      r_speed <= w_speed;
      r_hcnt  <= w_hcnt;
      r_fcnt  <= w_fcnt;
      r_bar   <= bar_of(w_speed);
      r_run   <= w_run;
      r_brst  <= w_brst;
      r_over  <= (w_state == S_OVER);
    end
  end

  assign bus.O_run        = r_run;
  assign bus.O_ball_reset = r_brst;
  assign bus.O_ball_speed = r_speed;
  assign bus.O_bar_speed  = r_bar;
  assign bus.O_score      = r_score;
  assign bus.O_lives      = r_lives;
  assign bus.O_state      = r_state;
  assign bus.O_game_over  = r_over;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: rule-level game model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_game_flow_ctrl;

  localparam int SF  = 4;
  localparam int LI  = 3;
  localparam int SH  = 5;
  localparam int SI  = 3;
  localparam int SM  = 8;
  localparam int BSI = 4;
`ifdef GAME_FLOW_PAUSE_EN
  localparam bit PAUSE = 1'b1;
`else
  localparam bit PAUSE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   passed = 0;
  int   cyc = 0;

  game_flow_ctrl_if bus();

  game_flow_ctrl #(
    .LIVES_INIT(LI), .SERVE_FRAMES(SF), .SPEEDUP_HITS(SH),
    .SPEED_INIT(SI), .SPEED_MAX(SM), .BAR_SPEED_INIT(BSI)
  ) dut (
    .I_clk(clk),
    .I_rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // game model: states 0 idle,1 serve,2 play,3 lost,4 over,5 pause
  int m_state, m_lives, m_score, m_hits, m_frames;
  bit m_valid = 1'b0;
  logic [3:0] h_vs, h_st, h_hit, h_lo;

  function automatic int to_bcd(int v);
    return ((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256
         + ((v / 10) % 10) * 16 + (v % 10);
  endfunction

  function automatic int exp_speed();
    int s;
    s = SI + m_hits / SH;
    return (s > SM) ? SM : s;
  endfunction

  function automatic int exp_bar();
    int b;
    b = BSI + exp_speed() - SI;
    return (b > 15) ? 15 : b;
  endfunction

  always @(posedge clk) begin
    bit et, es, eh, el;
    cyc++;
    if (rst) begin
      m_state = 0; m_lives = LI; m_score = 0; m_hits = 0; m_frames = 0;
      h_vs = 4'd0; h_st = 4'd0; h_hit = 4'd0; h_lo = 4'd0;
      m_valid = 1'b1;
    end else begin
      // an input sampled at edge n-3 acts on the outputs at edge n
      et = !h_vs[2] && h_vs[3];
      es = h_st[2] && !h_st[3];
      eh = h_hit[2] && !h_hit[3];
      el = h_lo[2] && !h_lo[3];
      case (m_state)
        0, 4: if (es) begin
          m_lives = LI; m_score = 0; m_hits = 0; m_frames = 0; m_state = 1;
        end
        1: if (et) begin
          m_frames++;
          if (m_frames == SF) begin m_frames = 0; m_state = 2; end
        end
        2: begin
          if (el) begin
            m_lives--; m_frames = 0; m_state = 3;
          end else if (es && PAUSE) begin
            m_state = 5;
          end else if (eh) begin
            if (m_score < 9999) m_score++;
            m_hits++;
          end
        end
        3: if (et) begin
          m_frames++;
          if (m_frames == SF) begin
            m_frames = 0; m_hits = 0;
            m_state = (m_lives == 0) ? 4 : 1;
          end
        end
        5: if (es) m_state = 2;
        default: m_state = 0;
      endcase
      h_vs  = {h_vs[2:0], bus.I_vs};
      h_st  = {h_st[2:0], bus.I_start};
      h_hit = {h_hit[2:0], bus.I_hit};
      h_lo  = {h_lo[2:0], bus.I_lose};
    end
  end

  always @(negedge clk) begin
    int e_run, e_brst;
    if (m_valid) begin
      e_run  = (m_state == 2) ? 1 : 0;
      e_brst = (m_state == 2 || m_state == 5) ? 0 : 1;
      total++;
      if (int'(bus.O_state) != m_state || int'(bus.O_lives) != m_lives
          || int'(bus.O_score) != to_bcd(m_score)
          || int'(bus.O_ball_speed) != exp_speed()
          || int'(bus.O_bar_speed) != exp_bar()
          || int'(bus.O_run) != e_run || int'(bus.O_ball_reset) != e_brst
          || int'(bus.O_game_over) != ((m_state == 4) ? 1 : 0))
        $display("FAIL model cyc%0d got st=%0d lv=%0d sc=%h sp=%0d bar=%0d run=%0d br=%0d go=%0d exp st=%0d lv=%0d sc=%h sp=%0d bar=%0d run=%0d br=%0d",
                 cyc, bus.O_state, bus.O_lives, bus.O_score, bus.O_ball_speed,
                 bus.O_bar_speed, bus.O_run, bus.O_ball_reset, bus.O_game_over,
                 m_state, m_lives, to_bcd(m_score), exp_speed(), exp_bar(),
                 e_run, e_brst);
      else
        passed++;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      passed++;
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse_start();
    bus.I_start = 1'b1; step(); bus.I_start = 1'b0; step();
  endtask

  task automatic hits(input int n);
    for (int i = 0; i < n; i++) begin
      bus.I_hit = 1'b1; step(); bus.I_hit = 1'b0; step();
    end
  endtask

  task automatic lose();
    bus.I_lose = 1'b1; step(); bus.I_lose = 1'b0; step();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      bus.I_vs = 1'b0; step(); bus.I_vs = 1'b1; step();
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, int'(bus.O_state), 0);
    chk({tag, "_run"}, int'(bus.O_run), 0);
    chk({tag, "_brst"}, int'(bus.O_ball_reset), 1);
    chk({tag, "_speed"}, int'(bus.O_ball_speed), SI);
    chk({tag, "_bar"}, int'(bus.O_bar_speed), BSI);
    chk({tag, "_score"}, int'(bus.O_score), 0);
    chk({tag, "_lives"}, int'(bus.O_lives), LI);
    chk({tag, "_over"}, int'(bus.O_game_over), 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.I_vs = 1'b1; bus.I_start = 1'b1;
    bus.I_hit = 1'b0; bus.I_lose = 1'b0;
    step(3);
    chk_reset_vals("rst");
    rst = 1'b0;
    step(3);
    chk("rel_idle", int'(bus.O_state), 0);
    step();
    chk("rel_serve", int'(bus.O_state), 1);
    bus.I_start = 1'b0;
    step();
    frames(3);
    step(4);
    chk("serve_hold", int'(bus.O_state), 1);
    frames(1);
    step(4);
    chk("play", int'(bus.O_state), 2);
    chk("play_run", int'(bus.O_run), 1);
    hits(10); step(4);
    chk("ramp_sp", int'(bus.O_ball_speed), 5);
    chk("ramp_bar", int'(bus.O_bar_speed), 6);
    chk("ramp_sc", int'(bus.O_score), 16'h0010);
    hits(40); step(4);
    chk("sat_sp", int'(bus.O_ball_speed), 8);
    chk("sat_bar", int'(bus.O_bar_speed), 9);
    hits(49); step(4);
    chk("sc99", int'(bus.O_score), 16'h0099);
    hits(1); step(4);
    chk("carry", int'(bus.O_score), 16'h0100);
    lose(); step(4);
    chk("lost", int'(bus.O_state), 3);
    chk("lives2", int'(bus.O_lives), 2);
    hits(1); step(4);
    chk("lost_hit", int'(bus.O_score), 16'h0100);
    frames(4); step(4);
    chk("reserve", int'(bus.O_state), 1);
    chk("reserve_sp", int'(bus.O_ball_speed), SI);
    frames(4); step(4);
    lose(); step(4);
    frames(8); step(4);
    chk("lives1", int'(bus.O_lives), 1);
    bus.I_hit = 1'b1; bus.I_lose = 1'b1;
    step();
    bus.I_hit = 1'b0; bus.I_lose = 1'b0;
    step(5);
    chk("hl_score", int'(bus.O_score), 16'h0100);
    chk("hl_lives", int'(bus.O_lives), 0);
    chk("hl_lost", int'(bus.O_state), 3);
    frames(4); step(4);
    chk("over", int'(bus.O_state), 4);
    chk("over_flag", int'(bus.O_game_over), 1);
    pulse_start(); step(4);
    chk("restart", int'(bus.O_state), 1);
    chk("restart_lv", int'(bus.O_lives), LI);
    frames(4); step(4);
    lose(); step(4);
    frames(1);
    bus.I_vs = 1'b0; step();
    bus.I_vs = 1'b1; step(2);
    rst = 1'b1;
    step();
    chk_reset_vals("midlost");
    rst = 1'b0;
    step(6);
    chk("post_rst", int'(bus.O_state), 0);
    pulse_start(); step(4);
    frames(4); step(4);
    chk("play2", int'(bus.O_state), 2);
    pulse_start(); step(4);
    if (PAUSE) begin
      chk("pause_st", int'(bus.O_state), 5);
      chk("pause_run", int'(bus.O_run), 0);
      hits(1); step(4);
      chk("pause_hit", int'(bus.O_score), 0);
      pulse_start(); step(4);
      chk("unpause", int'(bus.O_state), 2);
    end else begin
      chk("nopause_st", int'(bus.O_state), 2);
      chk("nopause_run", int'(bus.O_run), 1);
    end
    hits(9999); step(4);
    chk("sc9999", int'(bus.O_score), 16'h9999);
    hits(1); step(4);
    chk("sc_sat", int'(bus.O_score), 16'h9999);
    chk("sp_end", int'(bus.O_ball_speed), SM);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
